gb_noise_channel: RTL and testbench

- Game Boy channel-4 noise generator: 15/7-bit LFSR, programmable frequency timer, volume envelope and length counter.
- Drives the 4-bit `noise` input of the stereo mixer.
- Configured through a 4-register write port (NR41–NR44 equivalents).
- Paced by externally supplied timer, length and envelope tick strobes.

---
 rtl/gb_noise_channel.sv | 183 ++++++++++++++++++
 tb/tb_gb_noise_channel.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gb_noise_channel.sv
// rtl/gb_noise_channel.sv - Game Boy channel-4 noise generator (optional macro: NOISE_SHIFT_STALL_EN)
module gb_noise_channel #(
    parameter int          TIMER_W   = 22,
    parameter logic [14:0] LFSR_SEED = 15'h7FFF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       timer_tick,
    input  logic       len_tick,
    input  logic       env_tick,
    input  logic       wr_en,
    input  logic [1:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic [3:0] noise,
    output logic       active
);

    logic [14:0]        lfsr;
    logic [3:0]         volume;
    logic [6:0]         len_cnt;
    logic [TIMER_W-1:0] freq_timer;
    logic [2:0]         env_timer;

    logic [3:0]         init_vol;
    logic               env_up;
    logic [2:0]         env_per;
    logic [3:0]         shift;
    logic               width7;
    logic [2:0]         div_code;
    logic               len_en;

    logic               dac_en;
    logic               trigger;
    logic [6:0]         divisor;
    logic [TIMER_W-1:0] period;
    logic               lfsr_x;
    logic [14:0]        lfsr_stepped;
    logic               lfsr_stall;
    logic [6:0]         len_load;

    // The DAC is powered whenever the NR42 upper five bits are not all zero.
    assign dac_en  = |{init_vol, env_up};
    assign trigger = wr_en && (wr_addr == 2'd3) && wr_data[7];
    assign len_load = 7'd64 - {1'b0, wr_data[5:0]};

    // Divisor lookup for the frequency timer.
    always_comb begin
        divisor = 7'd8;
        case (div_code)
            3'd0: divisor = 7'd8;
            3'd1: divisor = 7'd16;
            3'd2: divisor = 7'd32;
            3'd3: divisor = 7'd48;
            3'd4: divisor = 7'd64;
            3'd5: divisor = 7'd80;
            3'd6: divisor = 7'd96;
            3'd7: divisor = 7'd112;
            default: divisor = 7'd8;
        endcase
    end

    assign period = TIMER_W'(divisor) << shift;

    // Next LFSR value; in 7-bit mode the feedback bit is also folded into bit 6.
    assign lfsr_x = lfsr[0] ^ lfsr[1];
    always_comb begin
        lfsr_stepped = {lfsr_x, lfsr[14:1]};
        if (width7) begin
            lfsr_stepped[6] = lfsr_x;
        end
    end

`ifdef NOISE_SHIFT_STALL_EN
    assign lfsr_stall = (shift >= 4'd14);
`else
    assign lfsr_stall = 1'b0;
`endif

    // Configuration register file (NR42/NR43/NR44 fields).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_vol <= '0;
            env_up   <= 1'b0;
            env_per  <= '0;
            shift    <= '0;
            width7   <= 1'b0;
            div_code <= '0;
            len_en   <= 1'b0;
        end else if (wr_en) begin
            case (wr_addr)
                2'd1: begin
                    init_vol <= wr_data[7:4];
                    env_up   <= wr_data[3];
                    env_per  <= wr_data[2:0];
                end
                2'd2: begin
                    shift    <= wr_data[7:4];
                    width7   <= wr_data[3];
                    div_code <= wr_data[2:0];
                end
                2'd3: len_en <= wr_data[6];
                default: ;
            endcase
        end
    end

    // Frequency timer: one LFSR step every `period` timer ticks; trigger restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            freq_timer <= '0;
            lfsr       <= LFSR_SEED;
        end else if (trigger) begin
            freq_timer <= period;
            lfsr       <= LFSR_SEED;
        end else if (timer_tick) begin
            if (freq_timer <= TIMER_W'(1)) begin
                freq_timer <= period;
                if (!lfsr_stall) begin
                    lfsr <= lfsr_stepped;
                end
            end else begin
                freq_timer <= freq_timer - TIMER_W'(1);
            end
        end
    end

    // Length counter and channel-enable flag, including the DAC-off shutdown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_cnt <= '0;
            active  <= 1'b0;
        end else if (trigger) begin
            active <= dac_en;
            if (len_cnt == 7'd0) begin
                len_cnt <= 7'd64;
            end
        end else begin
            if (wr_en && (wr_addr == 2'd0)) begin
                len_cnt <= len_load;
            end else if (len_tick && len_en && (len_cnt != 7'd0)) begin
                len_cnt <= len_cnt - 7'd1;
                if (len_cnt == 7'd1) begin
                    active <= 1'b0;
                end
            end
            if (wr_en && (wr_addr == 2'd1) && (wr_data[7:3] == 5'd0)) begin
                active <= 1'b0;
            end
        end
    end

    // Volume envelope: saturating step every env_per envelope ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            volume    <= '0;
            env_timer <= '0;
        end else if (trigger) begin
            volume    <= init_vol;
            env_timer <= env_per;
        end else if (env_tick && (env_per != 3'd0)) begin
            if (env_timer <= 3'd1) begin
                env_timer <= env_per;
                if (env_up && (volume != 4'hF)) begin
                    volume <= volume + 4'd1;
                end else if (!env_up && (volume != 4'h0)) begin
                    volume <= volume - 4'd1;
                end
            end else begin
                env_timer <= env_timer - 3'd1;
            end
        end
    end

    // Registered sample: silent while disabled or while the LFSR output bit is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            noise <= '0;
        end else begin
            noise <= (active && !lfsr[0]) ? volume : 4'd0;
        end
    end

endmodule

// File: tb/tb_gb_noise_channel.sv
// tb/tb_gb_noise_channel.sv - randomized self-checking bench for gb_noise_channel
module tb_gb_noise_channel;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       timer_tick = 1'b0;
    logic       len_tick = 1'b0;
    logic       env_tick = 1'b0;
    logic       wr_en = 1'b0;
    logic [1:0] wr_addr = 2'd0;
    logic [7:0] wr_data = 8'd0;
    logic [3:0] noise;
    logic       active;

    int errors = 0;
    int checks = 0;

    // reference model state (plain integers, tick-count view of timers)
    int m_lfsr, m_vol, m_len, m_act, m_noise, m_frem, m_erem;
    int c_ivol, c_up, c_eper, c_shift, c_w7, c_div, c_len_en;
    int divtab [8] = '{8, 16, 32, 48, 64, 80, 96, 112};

    always #5 clk = ~clk;

    gb_noise_channel dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .timer_tick (timer_tick),
        .len_tick   (len_tick),
        .env_tick   (env_tick),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .noise      (noise),
        .active     (active)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_period();
        return divtab[c_div] << c_shift;
    endfunction

    function automatic bit m_stall();
`ifdef NOISE_SHIFT_STALL_EN
        return c_shift >= 14;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int m_lfsr_next(input int v);
        int x;
        int r;
        x = (v ^ (v >> 1)) & 1;
        r = (v >> 1) | (x << 14);
        if (c_w7 != 0) r = (r & ~32'h40) | (x << 6);
        return r;
    endfunction

    task automatic model_reset();
        m_lfsr = 32'h7FFF; m_vol = 0; m_len = 0; m_act = 0; m_noise = 0;
        m_frem = 1; m_erem = 1;
        c_ivol = 0; c_up = 0; c_eper = 0; c_shift = 0; c_w7 = 0; c_div = 0; c_len_en = 0;
    endtask

    task automatic model_clock(input bit tt, input bit lt, input bit et,
                               input bit we, input logic [1:0] wa, input logic [7:0] wd);
        int nn;
        bit trig;
        nn = (m_act != 0 && (m_lfsr % 2) == 0) ? m_vol : 0;
        trig = we && wa == 2'd3 && wd[7];
        if (trig) begin
            m_act  = (c_ivol != 0 || c_up != 0) ? 1 : 0;
            if (m_len == 0) m_len = 64;
            m_frem = m_period();
            m_lfsr = 32'h7FFF;
            m_vol  = c_ivol;
            m_erem = (c_eper == 0) ? 1 : c_eper;
        end else begin
            if (tt) begin
                m_frem--;
                if (m_frem == 0) begin
                    m_frem = m_period();
                    if (!m_stall()) m_lfsr = m_lfsr_next(m_lfsr);
                end
            end
            if (et && c_eper != 0) begin
                m_erem--;
                if (m_erem == 0) begin
                    m_erem = c_eper;
                    if (c_up != 0 && m_vol < 15) m_vol++;
                    else if (c_up == 0 && m_vol > 0) m_vol--;
                end
            end
            if (we && wa == 2'd0) begin
                m_len = 64 - int'(wd[5:0]);
            end else if (lt && c_len_en != 0 && m_len != 0) begin
                m_len--;
                if (m_len == 0) m_act = 0;
            end
            if (we && wa == 2'd1 && wd[7:3] == 5'd0) m_act = 0;
        end
        if (we) begin
            case (wa)
                2'd1: begin c_ivol = wd[7:4]; c_up = wd[3]; c_eper = wd[2:0]; end
                2'd2: begin c_shift = wd[7:4]; c_w7 = wd[3]; c_div = wd[2:0]; end
                2'd3: c_len_en = wd[6];
                default: ;
            endcase
        end
        m_noise = nn;
    endtask

    task automatic step(input bit tt, input bit lt, input bit et,
                        input bit we, input logic [1:0] wa, input logic [7:0] wd);
        timer_tick = tt; len_tick = lt; env_tick = et;
        wr_en = we; wr_addr = wa; wr_data = wd;
        @(posedge clk);
        model_clock(tt, lt, et, we, wa, wd);
        #1;
        timer_tick = 1'b0; len_tick = 1'b0; env_tick = 1'b0; wr_en = 1'b0;
        check("noise", 32'(noise), m_noise);
        check("active", 32'(active), m_act);
        check("lfsr", 32'(dut.lfsr), m_lfsr);
        check("volume", 32'(dut.volume), m_vol);
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        step(1'b0, 1'b0, 1'b0, 1'b1, a, d);
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        check("rst_noise", 32'(noise), 0);
        check("rst_active", 32'(active), 0);
        check("rst_lfsr", 32'(dut.lfsr), 32'h7FFF);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        bit tt, lt, et, we;
        logic [1:0] wa;
        logic [7:0] wd;

        // reset and idle
        @(posedge clk);
        #1;
        do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);

        // basic 15-bit tone
        wr(2'd1, 8'hF0);
        wr(2'd2, 8'h00);
        wr(2'd3, 8'h80);
        check("tone_active", 32'(active), 1);
        run_ticks(8);
        check("tone_first_step", 32'(dut.lfsr), 32'h3FFF);
        check("tone_silent", 32'(noise), 0);
        run_ticks(112);
        check("tone_step15", 32'(dut.lfsr), 32'h4000);
        run_ticks(1);
        check("tone_loud", 32'(noise), 15);
        run_ticks(200);

        // 7-bit mode, well past two full sequence periods
        wr(2'd2, 8'h08);
        wr(2'd3, 8'h80);
        run_ticks(8 * 260);

        // envelope climb and saturation
        wr(2'd1, 8'h0B);
        wr(2'd3, 8'h80);
        for (int i = 1; i <= 60; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0);
            if (i == 3)  check("env_vol_3", 32'(dut.volume), 1);
            if (i == 44) check("env_vol_44", 32'(dut.volume), 14);
            if (i == 45) check("env_vol_45", 32'(dut.volume), 15);
        end
        check("env_vol_60", 32'(dut.volume), 15);

        // length counter expiry
        wr(2'd0, 8'h3E);
        wr(2'd3, 8'hC0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0);
        check("len_first_tick", 32'(active), 1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0);
        check("len_expire", 32'(active), 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
        check("len_noise", 32'(noise), 0);

        // DAC off while active, then trigger with DAC off
        wr(2'd1, 8'hF0);
        wr(2'd3, 8'h80);
        run_ticks(130);
        wr(2'd1, 8'h00);
        check("dac_off", 32'(active), 0);
        run_ticks(20);
        wr(2'd3, 8'h80);
        check("trig_dac_off_act", 32'(active), 0);
        check("trig_dac_off_lfsr", 32'(dut.lfsr), 32'h7FFF);

        // trigger coinciding with every tick; NR41 write coinciding with len_tick
        wr(2'd1, 8'hF3);
        step(1'b1, 1'b1, 1'b1, 1'b1, 2'd3, 8'hC0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 8'h3F);
        check("len_write_wins", 32'(dut.len_cnt), 1);
        run_ticks(50);

        // shift 14: stalled LFSR with the macro, otherwise a very long period
        wr(2'd2, 8'hE0);
        wr(2'd3, 8'h80);
`ifdef NOISE_SHIFT_STALL_EN
        run_ticks(10000);
`else
        run_ticks(2000);
`endif
        check("shift14_lfsr", 32'(dut.lfsr), 32'h7FFF);

        // randomized mix of writes and ticks, with a reset in the middle
        for (int n = 0; n < 4000; n++) begin
            if (n == 2000) do_reset();
            tt = ($urandom % 4) != 0;
            lt = ($urandom % 8) == 0;
            et = ($urandom % 6) == 0;
            we = ($urandom % 8) == 0;
            wa = 2'($urandom);
            wd = 8'($urandom);
            if (wa == 2'd2 && ($urandom % 4) != 0) wd[7:4] = 4'($urandom % 3);
            if (wa == 2'd1 && ($urandom % 4) != 0) wd[7:4] = 4'($urandom_range(1, 15));
            if (wa == 2'd3 && ($urandom % 2) != 0) wd[7] = 1'b1;
            step(tt, lt, et, we, wa, wd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
